// File: rtl/vmem_fb_if.sv
// Host/scan-out bus of the frame buffer: read port, host write port and
// rectangle-fill command/status, with master (host) and slave (memory) views.
interface vmem_fb_if #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int PIX_W = 24
);
    localparam int HW = $clog2(H_RES);
    localparam int VW = $clog2(V_RES);

    logic [HW-1:0]    raddr_h_i;
    logic [VW-1:0]    raddr_v_i;
    logic             re_i;
    logic [PIX_W-1:0] rdata_o;
    logic             rvalid_o;

    logic [HW-1:0]    waddr_h_i;
    logic [VW-1:0]    waddr_v_i;
    logic             we_i;
    logic [PIX_W-1:0] wdata_i;
    logic             wready_o;

    logic             fill_start_i;
    logic [HW-1:0]    fill_x0_i;
    logic [HW-1:0]    fill_x1_i;
    logic [VW-1:0]    fill_y0_i;
    logic [VW-1:0]    fill_y1_i;
    logic [PIX_W-1:0] fill_color_i;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  raddr_h_i, raddr_v_i, re_i,
        output rdata_o, rvalid_o,
        input  waddr_h_i, waddr_v_i, we_i, wdata_i,
        output wready_o,
        input  fill_start_i, fill_x0_i, fill_x1_i, fill_y0_i, fill_y1_i, fill_color_i,
        output busy_o, done_o
    );

    modport master (
        output raddr_h_i, raddr_v_i, re_i,
        input  rdata_o, rvalid_o,
        output waddr_h_i, waddr_v_i, we_i, wdata_i,
        input  wready_o,
        output fill_start_i, fill_x0_i, fill_x1_i, fill_y0_i, fill_y1_i, fill_color_i,
        input  busy_o, done_o
    );
endinterface

// File: rtl/vmem_fb.sv
// Single-clock frame buffer with registered read port, bounds-checked host
// writes and a row-major rectangle-fill engine that owns the write port while busy.
module vmem_fb #(
    parameter int               H_RES      = 640,
    parameter int               V_RES      = 480,
    parameter int               PIX_W      = 24,
    parameter logic [PIX_W-1:0] INIT_COLOR = 24'h56124E,
    localparam int              HW         = $clog2(H_RES),
    localparam int              VW         = $clog2(V_RES)
) (
    input logic      clk,
    input logic      rst,
    vmem_fb_if.slave bus
);
    localparam int DEPTH = H_RES * V_RES;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [PIX_W-1:0] mem [DEPTH] = '{default: INIT_COLOR};

    logic [HW-1:0]    cur_x, x0_q, x1_q;
    logic [VW-1:0]    cur_y, y1_q;
    logic [PIX_W-1:0] color_q;

    logic [HW-1:0]    x1_clip;
    logic [VW-1:0]    y1_clip;
    logic             fill_empty;
    logic             fill_last;
    logic             rd_ok, wr_ok;
    logic             wen;
    logic [AW-1:0]    wa;
    logic [PIX_W-1:0] wd;

    function automatic logic [AW-1:0] lin(input logic [HW-1:0] x, input logic [VW-1:0] y);
        return AW'(int'(y) * H_RES + int'(x));
    endfunction

    always_comb begin
        x1_clip    = (int'(bus.fill_x1_i) > H_RES - 1) ? HW'(H_RES - 1) : bus.fill_x1_i;
        y1_clip    = (int'(bus.fill_y1_i) > V_RES - 1) ? VW'(V_RES - 1) : bus.fill_y1_i;
        fill_empty = (int'(bus.fill_x0_i) >= H_RES) || (int'(bus.fill_y0_i) >= V_RES) ||
                     (bus.fill_x0_i > x1_clip) || (bus.fill_y0_i > y1_clip);
        fill_last  = (cur_x == x1_q) && (cur_y == y1_q);
        rd_ok      = (int'(bus.raddr_h_i) < H_RES) && (int'(bus.raddr_v_i) < V_RES);
        wr_ok      = (int'(bus.waddr_h_i) < H_RES) && (int'(bus.waddr_v_i) < V_RES);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.fill_start_i) state_n = fill_empty ? S_DONE : S_FILL;
            S_FILL:  if (fill_last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Cursor/bounds need no reset: they are always reloaded on leaving IDLE.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.fill_start_i) begin
            cur_x   <= bus.fill_x0_i;
            cur_y   <= bus.fill_y0_i;
            x0_q    <= bus.fill_x0_i;
            x1_q    <= x1_clip;
            y1_q    <= y1_clip;
            color_q <= bus.fill_color_i;
        end else if (state == S_FILL) begin
            if (cur_x == x1_q) begin
                cur_x <= x0_q;
                cur_y <= cur_y + 1'b1;
            end else begin
                cur_x <= cur_x + 1'b1;
            end
        end
    end

    // Single write port: fill engine has priority; a reset edge suppresses the fill write.
    always_comb begin
        wen = 1'b0;
        wa  = '0;
        wd  = '0;
        if (state == S_FILL) begin
            wen = !rst;
            wa  = lin(cur_x, cur_y);
            wd  = color_q;
        end else if (bus.we_i && wr_ok) begin
            wen = 1'b1;
            wa  = lin(bus.waddr_h_i, bus.waddr_v_i);
            wd  = bus.wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wen) mem[wa] <= wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rdata_o  <= '0;
            bus.rvalid_o <= 1'b0;
        end else begin
            bus.rvalid_o <= bus.re_i;
            if (bus.re_i) bus.rdata_o <= rd_ok ? mem[lin(bus.raddr_h_i, bus.raddr_v_i)] : '0;
        end
    end

    always_comb begin
        bus.busy_o   = (state == S_FILL);
        bus.done_o   = (state == S_DONE);
        bus.wready_o = (state != S_FILL);
    end
endmodule

// File: tb/tb_vmem_fb.sv
// Directed self-checking bench for vmem_fb: reset, power-on contents, host
// read/write, fills (normal, clipped, empty), contention and reset mid-fill.
module tb_vmem_fb;
    localparam int          H    = 640;
    localparam int          V    = 480;
    localparam int          PW   = 24;
    localparam int          HW   = $clog2(H);
    localparam int          VW   = $clog2(V);
    localparam logic [23:0] INIT = 24'h56124E;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vmem_fb_if #(.H_RES(H), .V_RES(V), .PIX_W(PW)) bus ();

    vmem_fb #(.H_RES(H), .V_RES(V), .PIX_W(PW), .INIT_COLOR(INIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.raddr_h_i    = '0;
        bus.raddr_v_i    = '0;
        bus.re_i         = 1'b0;
        bus.waddr_h_i    = '0;
        bus.waddr_v_i    = '0;
        bus.we_i         = 1'b0;
        bus.wdata_i      = '0;
        bus.fill_start_i = 1'b0;
        bus.fill_x0_i    = '0;
        bus.fill_x1_i    = '0;
        bus.fill_y0_i    = '0;
        bus.fill_y1_i    = '0;
        bus.fill_color_i = '0;
    endtask

    task automatic rd(input int x, input int y, output logic [23:0] d, output logic v);
        bus.raddr_h_i = HW'(x);
        bus.raddr_v_i = VW'(y);
        bus.re_i      = 1'b1;
        tick();
        d         = bus.rdata_o;
        v         = bus.rvalid_o;
        bus.re_i  = 1'b0;
    endtask

    task automatic wr(input int x, input int y, input logic [23:0] d);
        bus.waddr_h_i = HW'(x);
        bus.waddr_v_i = VW'(y);
        bus.wdata_i   = d;
        bus.we_i      = 1'b1;
        tick();
        bus.we_i      = 1'b0;
    endtask

    task automatic set_fill(input int x0, input int x1, input int y0, input int y1,
                            input logic [23:0] c);
        bus.fill_x0_i    = HW'(x0);
        bus.fill_x1_i    = HW'(x1);
        bus.fill_y0_i    = VW'(y0);
        bus.fill_y1_i    = VW'(y1);
        bus.fill_color_i = c;
        bus.fill_start_i = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.rdata_o !== 24'h0) begin bad++; $display("FAIL reset_rdata got=%h want=000000", bus.rdata_o); end
        total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", bus.rvalid_o); end
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_o); end
        total++; if (bus.wready_o !== 1'b1) begin bad++; $display("FAIL reset_wready got=%b want=1", bus.wready_o); end
    endtask

    task automatic test_power_on();
        logic [23:0] d;
        logic        v;
        rd(0, 0, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL pwr_00 got=%h want=%h", d, INIT); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL pwr_00_valid got=%b want=1", v); end
        rd(639, 479, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL pwr_639_479 got=%h want=%h", d, INIT); end
        tick();
        total++; if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL rvalid_drop got=%b want=0", bus.rvalid_o); end
        total++; if (bus.rdata_o !== INIT) begin bad++; $display("FAIL rdata_hold got=%h want=%h", bus.rdata_o, INIT); end
    endtask

    task automatic test_write_read();
        logic [23:0] d;
        logic        v;
        wr(10, 20, 24'hABCDEF);
        rd(10, 20, d, v);
        total++; if (d !== 24'hABCDEF) begin bad++; $display("FAIL wr_10_20 got=%h want=abcdef", d); end
        wr(700, 5, 24'h123123);
        rd(700, 5, d, v);
        total++; if (d !== 24'h0) begin bad++; $display("FAIL oob_read got=%h want=000000", d); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL oob_valid got=%b want=1", v); end
        rd(188, 5, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL oob_no_alias got=%h want=%h", d, INIT); end
        // read-during-write at the same address returns the old word
        bus.waddr_h_i = HW'(11);
        bus.waddr_v_i = VW'(20);
        bus.wdata_i   = 24'h123456;
        bus.we_i      = 1'b1;
        rd(11, 20, d, v);
        bus.we_i      = 1'b0;
        total++; if (d !== INIT) begin bad++; $display("FAIL rdw_old got=%h want=%h", d, INIT); end
        rd(11, 20, d, v);
        total++; if (d !== 24'h123456) begin bad++; $display("FAIL rdw_new got=%h want=123456", d); end
    endtask

    task automatic test_fill();
        logic [23:0] d;
        logic        v;
        int          nb = 0;
        int          nd = 0;
        int          done_at = -1;
        set_fill(2, 4, 3, 4, 24'h00FF00);
        tick();
        bus.fill_start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy_o === 1'b1) nb++;
            if (bus.done_o === 1'b1) begin nd++; done_at = i; end
            tick();
        end
        total++; if (nb !== 6) begin bad++; $display("FAIL fill_busy_cycles got=%0d want=6", nb); end
        total++; if (nd !== 1) begin bad++; $display("FAIL fill_done_pulses got=%0d want=1", nd); end
        total++; if (done_at !== 6) begin bad++; $display("FAIL fill_done_cycle got=%0d want=6", done_at); end
        for (int y = 3; y <= 4; y++) begin
            for (int x = 2; x <= 4; x++) begin
                rd(x, y, d, v);
                total++; if (d !== 24'h00FF00) begin bad++; $display("FAIL fill_px_%0d_%0d got=%h want=00ff00", x, y, d); end
            end
        end
        rd(5, 3, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL fill_outside_5_3 got=%h want=%h", d, INIT); end
        rd(2, 5, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL fill_outside_2_5 got=%h want=%h", d, INIT); end
    endtask

    task automatic test_clip_empty();
        logic [23:0] d;
        logic        v;
        int          nb = 0;
        int          nd = 0;
        set_fill(638, 1000, 478, 511, 24'h0000FF);
        tick();
        bus.fill_start_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy_o === 1'b1) nb++;
            if (bus.done_o === 1'b1) nd++;
            tick();
        end
        total++; if (nb !== 4) begin bad++; $display("FAIL clip_busy_cycles got=%0d want=4", nb); end
        total++; if (nd !== 1) begin bad++; $display("FAIL clip_done_pulses got=%0d want=1", nd); end
        rd(639, 479, d, v);
        total++; if (d !== 24'h0000FF) begin bad++; $display("FAIL clip_corner got=%h want=0000ff", d); end
        rd(638, 478, d, v);
        total++; if (d !== 24'h0000FF) begin bad++; $display("FAIL clip_origin got=%h want=0000ff", d); end
        rd(637, 479, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL clip_outside got=%h want=%h", d, INIT); end

        nb = 0;
        set_fill(5, 4, 0, 0, 24'hFFFFFF);
        tick();
        bus.fill_start_i = 1'b0;
        total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL empty_done got=%b want=1", bus.done_o); end
        for (int i = 0; i < 5; i++) begin
            if (bus.busy_o === 1'b1) nb++;
            tick();
        end
        total++; if (nb !== 0) begin bad++; $display("FAIL empty_busy_cycles got=%0d want=0", nb); end
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL empty_done_drop got=%b want=0", bus.done_o); end
        rd(5, 0, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL empty_no_write got=%h want=%h", d, INIT); end
    endtask

    task automatic test_contention();
        logic [23:0] d;
        logic        v;
        int          nb = 0;
        int          nd = 0;
        // host write and fill start in the same IDLE cycle
        bus.waddr_h_i = HW'(23);
        bus.waddr_v_i = VW'(30);
        bus.wdata_i   = 24'hABABAB;
        bus.we_i      = 1'b1;
        set_fill(20, 22, 30, 30, 24'h111111);
        tick();
        total++; if (bus.wready_o !== 1'b0) begin bad++; $display("FAIL cont_wready got=%b want=0", bus.wready_o); end
        if (bus.busy_o === 1'b1) nb++;
        bus.waddr_h_i = HW'(50);
        bus.waddr_v_i = VW'(50);
        bus.wdata_i   = 24'h777777;
        set_fill(60, 61, 60, 60, 24'h222222);
        tick();
        bus.we_i         = 1'b0;
        bus.fill_start_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.busy_o === 1'b1) nb++;
            if (bus.done_o === 1'b1) nd++;
            tick();
        end
        total++; if (nb !== 3) begin bad++; $display("FAIL cont_busy_cycles got=%0d want=3", nb); end
        total++; if (nd !== 1) begin bad++; $display("FAIL cont_done_pulses got=%0d want=1", nd); end
        rd(50, 50, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL cont_dropped_write got=%h want=%h", d, INIT); end
        rd(60, 60, d, v);
        total++; if (d !== INIT) begin bad++; $display("FAIL cont_ignored_fill got=%h want=%h", d, INIT); end
        rd(23, 30, d, v);
        total++; if (d !== 24'hABABAB) begin bad++; $display("FAIL cont_same_cycle_write got=%h want=ababab", d); end
        rd(22, 30, d, v);
        total++; if (d !== 24'h111111) begin bad++; $display("FAIL cont_fill_px got=%h want=111111", d); end
    endtask

    task automatic test_reset_mid_fill();
        logic [23:0] d;
        logic [23:0] want;
        logic        v;
        int          nd = 0;
        int          changed = 0;
        set_fill(100, 102, 100, 101, 24'h333333);
        tick();
        bus.fill_start_i = 1'b0;
        tick();
        tick();
        tick();
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", bus.busy_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy_o); end
        total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.done_o); end
        for (int i = 0; i < 6; i++) begin
            if (bus.done_o === 1'b1) nd++;
            tick();
        end
        total++; if (nd !== 0) begin bad++; $display("FAIL rstmid_done_pulses got=%0d want=0", nd); end
        for (int y = 100; y <= 101; y++) begin
            for (int x = 100; x <= 102; x++) begin
                rd(x, y, d, v);
                want = (y == 100) ? 24'h333333 : INIT;
                if (d === 24'h333333) changed++;
                total++; if (d !== want) begin bad++; $display("FAIL rstmid_px_%0d_%0d got=%h want=%h", x, y, d, want); end
            end
        end
        total++; if (changed !== 3) begin bad++; $display("FAIL rstmid_changed got=%0d want=3", changed); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_write_read();
        test_fill();
        test_clip_empty();
        test_contention();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
